// File: rtl/multu_hilo_unit_pkg.sv
// Shared types for the MULTU / HI-LO unit: FSM encoding and counter sizing.
package multu_hilo_unit_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/multu_hilo_unit.sv
// Multi-cycle radix-2 unsigned multiplier with architectural HI/LO registers.
// Executes MULTU in exactly WIDTH RUN cycles and accepts MTHI/MTLO writes when not running.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// MUL_IDLE | waiting; start accepted, hi_we/lo_we honoured
// MUL_RUN  | one multiplier bit consumed per cycle; busy=1, writes dropped
// MUL_DONE | hi/lo hold the new product for one cycle; start accepted again
module multu_hilo_unit
  import multu_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNTW     = cnt_width(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  mul_state_t       state, state_nxt;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH:0]   psum;
  logic             accept;
  logic             finish;

  // Down-counter reaches zero on the last RUN cycle; that step's result is the product.
  assign accept   = start && (state != MUL_RUN);
  assign finish   = (state == MUL_RUN) && (cnt == '0);
  assign psum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_step = {1'b0, psum, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) state <= MUL_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (cnt == '0) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_RUN : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL_RUN);
    done = (state == MUL_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        mcand <= srca;
        acc   <= {{(WIDTH+1){1'b0}}, srcb};
        cnt   <= CNT_LAST;
      end else if (state == MUL_RUN) begin
        acc <= acc_step;
        cnt <= cnt - 1'b1;
      end

      if (finish) begin
        hi <= acc_step[2*WIDTH-1:WIDTH];
        lo <= acc_step[WIDTH-1:0];
      end else if (state != MUL_RUN) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Scoreboard bench for multu_hilo_unit: stimulus pushes expected {hi,lo}, a monitor checks on done.
module tb_multu_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] srca, srcb, wdata;
  logic         hi_we, lo_we;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .srca  (srca),
    .srcb  (srcb),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    srca  = a;
    srcb  = b;
    @(negedge clk);
    start = 1'b0;
    srca  = ~a;
    srcb  = ~b;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", n);
    end
  endtask

  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
    exp_q.push_back(p);
    issue(a, b);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; srca = '0; srcb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    fork
      begin : monitor
        logic [2*W-1:0] e;
        int run_len = 0;
        forever begin
          @(negedge clk);
          if (busy) begin
            run_len++;
          end else if (done) begin
            chk("busy_len", W'(run_len), W'(W));
            run_len = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: hi=%h lo=%h with no multiply pending", hi, lo);
            end else begin
              e = exp_q.pop_front();
              chk("prod_hi", hi, e[2*W-1:W]);
              chk("prod_lo", lo, e[W-1:0]);
            end
          end else begin
            run_len = 0;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);

    mul(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    // start mid-RUN must be ignored
    exp_q.push_back(64'd6);
    issue(32'd2, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1; srca = 32'd7; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo, 32'd6);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("both_hi", hi, 32'hA5A5_A5A5);
    chk("both_lo", lo, 32'hA5A5_A5A5);

    // MTLO during RUN is dropped; hi/lo hold old values while busy
    exp_q.push_back(64'd6);
    issue(32'd2, 32'd3);
    repeat (4) @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("run_lo_hold", lo, 32'hA5A5_A5A5);
    chk("run_hi_hold", hi, 32'hA5A5_A5A5);
    wait_done();
    @(negedge clk);

    // MTHI together with start: write lands, product overwrites later
    exp_q.push_back(64'd42);
    hi_we = 1'b1; wdata = 32'h1111_2222;
    issue(32'd6, 32'd7);
    hi_we = 1'b0;
    chk("mthi_with_start", hi, 32'h1111_2222);
    wait_done();
    // start accepted in DONE
    exp_q.push_back(64'd81);
    issue(32'd9, 32'd9);
    chk("restart_busy", W'(busy), 32'd1);
    wait_done();
    @(negedge clk);

    // reset at RUN cycle 16 aborts with no done pulse
    issue(32'd5, 32'd5);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    repeat (40) @(negedge clk);
    chk("queue_empty", W'(exp_q.size()), '0);

    mul(32'd4, 32'd4, 64'h0000_0000_0000_0010);

    chk("final_queue_empty", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
